// File: rtl/lc3_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_responder
// Brief    : LC3 data-memory responder with wait states, keyboard FIFO
//            (KBSR/KBDR), display register (DSR/DDR) and backing RAM.
// Revision : 1.0  initial release
// ============================================================================
module lc3_mem_responder #(
  parameter int RAM_AW      = 10,
  parameter int WAIT_STATES = 1,
  parameter int KB_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_ready,
  output logic        dsp_valid,
  output logic [7:0]  dsp_data,
  input  logic        dsp_ready
);

  localparam int               C_KB_PW     = $clog2(KB_DEPTH);
  localparam logic [C_KB_PW:0] C_KB_FULL   = (C_KB_PW + 1)'(KB_DEPTH);
  localparam logic [3:0]       C_WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_wait_cnt, w_wait_cnt_nxt;
  logic [15:0]        r_rdata, w_rdata;
  logic [15:0]        r_ram [0:(2**RAM_AW)-1];
  logic [7:0]         r_kb_mem [0:KB_DEPTH-1];
  logic [C_KB_PW-1:0] r_kb_head, r_kb_tail;
  logic [C_KB_PW:0]   r_kb_count;
  logic               r_drop;

  logic w_accept, w_is_dev, w_hit_kbsr, w_hit_kbdr, w_hit_dsr, w_hit_ddr;
  logic w_kb_empty, w_kb_full, w_kb_push, w_kb_pop, w_dsp_eff;
  logic w_ddr_wr, w_dsr_rd, w_ram_wr;

  // Gating with reset keeps both ready outputs low while reset is held.
  assign req_ready  = reset & (r_state == S_IDLE);
  assign kb_ready   = reset & ~w_kb_full;
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = resp_valid ? r_rdata : 16'h0000;

  assign w_accept   = req_valid & req_ready;
  assign w_is_dev   = (req_addr[15:9] == 7'h7F);
  assign w_hit_kbsr = (req_addr == 16'hFE00);
  assign w_hit_kbdr = (req_addr == 16'hFE02);
  assign w_hit_dsr  = (req_addr == 16'hFE04);
  assign w_hit_ddr  = (req_addr == 16'hFE06);

  assign w_kb_empty = (r_kb_count == '0);
  assign w_kb_full  = (r_kb_count == C_KB_FULL);
  assign w_kb_push  = kb_valid & kb_ready;
  assign w_kb_pop   = w_accept & ~req_write & w_hit_kbdr & ~w_kb_empty;
  // A display handshake on this edge frees the slot for a same-edge DDR write.
  assign w_dsp_eff  = dsp_valid & ~dsp_ready;
  assign w_ddr_wr   = w_accept & req_write & w_hit_ddr;
  assign w_dsr_rd   = w_accept & ~req_write & w_hit_dsr;
  assign w_ram_wr   = w_accept & req_write & ~w_is_dev;

  always_comb begin
    w_rdata = 16'h0000;
    if (!req_write) begin
      if (!w_is_dev)
        w_rdata = r_ram[req_addr[RAM_AW-1:0]];
      else if (w_hit_kbsr)
        w_rdata = {~w_kb_empty, 15'b0};
      else if (w_hit_kbdr && !w_kb_empty)
        w_rdata = {8'h00, r_kb_mem[r_kb_head]};
      else if (w_hit_dsr)
        w_rdata = {~w_dsp_eff, r_drop, 14'b0};
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (WAIT_STATES > 0) begin
            w_state_nxt    = S_WAIT;
            w_wait_cnt_nxt = C_WAIT_INIT;
          end else begin
            w_state_nxt = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == 4'd0)
          w_state_nxt = S_RESP;
        else
          w_wait_cnt_nxt = r_wait_cnt - 4'd1;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_ram_wr)
      r_ram[req_addr[RAM_AW-1:0]] <= req_wdata;
  end

  always_ff @(posedge clk) begin
    if (w_kb_push)
      r_kb_mem[r_kb_tail] <= kb_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_rdata    <= 16'h0000;
      r_kb_head  <= '0;
      r_kb_tail  <= '0;
      r_kb_count <= '0;
      r_drop     <= 1'b0;
      dsp_valid  <= 1'b0;
      dsp_data   <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_accept)
        r_rdata <= w_rdata;

      if (w_kb_push)
        r_kb_tail <= r_kb_tail + 1'b1;
      if (w_kb_pop)
        r_kb_head <= r_kb_head + 1'b1;
      case ({w_kb_push, w_kb_pop})
        2'b10:   r_kb_count <= r_kb_count + 1'b1;
        2'b01:   r_kb_count <= r_kb_count - 1'b1;
        default: r_kb_count <= r_kb_count;
      endcase

      if (w_ddr_wr && w_dsp_eff)
        r_drop <= 1'b1;
      else if (w_dsr_rd)
        r_drop <= 1'b0;

      if (w_ddr_wr && !w_dsp_eff) begin
        dsp_valid <= 1'b1;
        dsp_data  <= req_wdata[7:0];
      end else if (dsp_valid && dsp_ready) begin
        dsp_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/lc3_mem_responder.md
Name: lc3_mem_responder

Overview:
- Bus-side responder for the LC3 core's data-memory interface: accepts CPU load/store requests over a valid/ready handshake and returns read data or a write acknowledgement after a programmable number of wait states.
- Decodes the LC3 device page: KBSR/KBDR back a keyboard receive FIFO, and DSR/DDR back a single-entry display transmit register.
- All other addresses map to a word-addressed backing RAM.
- Sits between the control unit's memory-access path and the board I/O.

Parameters:
- RAM_AW, 10, backing RAM address width; depth is 2^RAM_AW 16-bit words.
- WAIT_STATES, 1, extra cycles between request acceptance and response; range 0..15.
- KB_DEPTH, 4, keyboard FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  16  word address.
- req_wdata  in  16  store data.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  16  load data; 0x0000 for stores.
- kb_valid  in  1  keyboard byte available.
- kb_data  in  8  keyboard byte.
- kb_ready  out  1  FIFO can take a byte.
- dsp_valid  out  1  display byte pending.
- dsp_data  out  8  display byte.
- dsp_ready  in  1  display sink accepts the byte.

Behaviour:
Reset (reset=0, asynchronous):
- FSM goes to IDLE; req_ready=0 while reset is asserted, then 1 from the first cycle after release.
- resp_valid=0, resp_rdata=0, dsp_valid=0, dsp_data=0, kb_ready=0 (1 after release).
- FIFO emptied, drop flag cleared, wait counter cleared.
- Any in-flight request is discarded and produces no response.
- RAM contents are not initialised.

FSM:
- IDLE: req_ready=1. A request is accepted on the edge where req_valid&req_ready.
  - If WAIT_STATES>0, go to WAIT with counter=WAIT_STATES-1.
  - Otherwise go to RESP.
- WAIT: req_ready=0. Decrement the counter; at 0, go to RESP.
- RESP: req_ready=0, resp_valid=1 for exactly one cycle, then return to IDLE.
- Latency: resp_valid is high in cycle N+WAIT_STATES+1, where N is the acceptance edge.
- Minimum spacing between accepted requests is WAIT_STATES+2 cycles.

Address decode (latched at acceptance):
- Address below 0xFE00: RAM[addr[RAM_AW-1:0]]. Higher bits are ignored, so addresses alias.
- 0xFE00 KBSR: read returns {fifo_nonempty, 15'b0}. Writes are ignored.
- 0xFE02 KBDR: read returns {8'b0, FIFO head}, and the FIFO pops on the acceptance edge. If the FIFO is empty, the read returns 0x0000 with no pop. Writes are ignored.
- 0xFE04 DSR: read returns {~dsp_valid_eff, drop, 14'b0}. The read clears the drop flag. Writes are ignored.
- 0xFE06 DDR: write with ~dsp_valid_eff loads dsp_data=req_wdata[7:0] and sets dsp_valid on the next cycle. Write while busy: data is dropped and drop is set. Reads return 0x0000.
- Other addresses from 0xFE00 to 0xFFFF: read 0x0000, writes ignored.
- dsp_valid_eff = dsp_valid & ~dsp_ready. A display handshake completing on the acceptance edge frees the slot for that same write.
- Read data is captured at acceptance and held in resp_rdata until RESP. resp_rdata returns to 0 outside RESP.
- RAM stores commit on the acceptance edge.

Keyboard FIFO:
- kb_ready = ~full.
- A push happens when kb_valid&kb_ready.
- A simultaneous push and KBDR pop with the FIFO neither empty nor full leaves the count unchanged, and head/tail both advance.
- When full, kb_ready=0 even if a pop occurs in the same cycle, so no byte is ever lost.
- Pointers wrap modulo KB_DEPTH; the count is RAM-free and ranges 0..KB_DEPTH.

Display:
- dsp_valid stays high and dsp_data stays stable until the dsp_valid&dsp_ready edge, after which dsp_valid=0.

Test Plan:
1. WAIT_STATES=1: store 0x1234 to 0x3000, then load 0x3000. Acceptance at edge N gives resp_valid only in cycle N+2, with rdata 0x1234. req_ready stays 0 through RESP.
2. Push bytes 0x41, 0x42 from the keyboard. KBSR reads 0x8000. Two KBDR reads return 0x0041 then 0x0042. A third KBDR read returns 0x0000, and KBSR then reads 0x0000.
3. Push 4 bytes with KB_DEPTH=4: kb_ready drops to 0, and a 5th kb_valid is not accepted. One KBDR pop lets kb_ready return to 1 the next cycle. Push 0x45 and read it back after the others to show correct pointer wrap.
4. Hold dsp_ready=0 and write DDR 0x0058: dsp_valid=1, dsp_data=0x58. A second DDR write of 0x0059 is dropped and DSR reads 0x4000. A subsequent DSR read returns 0x0000. Pulse dsp_ready and DSR reads 0x8000.
5. Assert reset low in WAIT after a KBDR read is accepted: no resp_valid appears, the FIFO is empty, all outputs are 0, and req_ready returns to 1 on the first cycle after release.
6. WAIT_STATES=0: a load of 0xFE10 responds in cycle N+1 with 0x0000. A store to 0xFE10 leaves RAM and the device registers unchanged.
